// File: rtl/i2s_sample_fifo_if.sv
// Push-side handshake bundle for i2s_sample_fifo: a stereo sample pair with valid/ready.
interface i2s_sample_fifo_if #(
    parameter int BITWIDTH = 24
);
    logic [BITWIDTH-1:0] s_l;
    logic [BITWIDTH-1:0] s_r;
    logic                s_valid;
    logic                s_ready;

    modport master (
        output s_l,
        output s_r,
        output s_valid,
        input  s_ready
    );

    modport slave (
        input  s_l,
        input  s_r,
        input  s_valid,
        output s_ready
    );
endinterface

// File: rtl/i2s_sample_fifo.sv
// Stereo sample FIFO feeding the I2S transmitter: one pair is popped per falling LR edge.
// Define I2S_FIFO_HOLD_EN to repeat the last sample on underrun instead of muting.
module i2s_sample_fifo #(
    parameter int BITWIDTH   = 24,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_ctl_clk,
    input  logic                  i_ctl_rst,
    i2s_sample_fifo_if.slave      s_if,
    input  logic                  i_lrck,
    output logic [BITWIDTH-1:0]   o_wave_out_l,
    output logic [BITWIDTH-1:0]   o_wave_out_r,
    output logic [DEPTH_LOG2:0]   o_level,
    output logic                  o_underrun,
    output logic [15:0]           o_underrun_cnt
);
    localparam int                DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [2*BITWIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wptr;
    logic [DEPTH_LOG2-1:0] r_rptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_lrck_d;
    logic [BITWIDTH-1:0]   r_wave_l;
    logic [BITWIDTH-1:0]   r_wave_r;
    logic                  r_underrun;
    logic [15:0]           r_underrun_cnt;

    logic w_ready;
    logic w_tick;
    logic w_push;
    logic w_pop;
    logic w_empty_tick;

    // Ready comes only from the registered level, never from lrck.
    assign w_ready      = (r_level != LEVEL_FULL);
    assign w_tick       = r_lrck_d & ~i_lrck;
    assign w_push       = s_if.s_valid & w_ready;
    assign w_pop        = w_tick & (r_level != '0);
    assign w_empty_tick = w_tick & (r_level == '0);

    always_ff @(posedge i_ctl_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {s_if.s_l, s_if.s_r};
        end
    end

    always_ff @(posedge i_ctl_clk) begin
        if (i_ctl_rst) begin
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_level        <= '0;
            r_lrck_d       <= 1'b0;
            r_wave_l       <= '0;
            r_wave_r       <= '0;
            r_underrun     <= 1'b0;
            r_underrun_cnt <= '0;
        end else begin
            r_lrck_d   <= i_lrck;
            r_underrun <= w_empty_tick;

            if (w_push) begin
                r_wptr <= r_wptr + DEPTH_LOG2'(1);
            end

            // A push landing on an empty-FIFO tick is stored, not bypassed.
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (DEPTH_LOG2 + 1)'(1);
                2'b01:   r_level <= r_level - (DEPTH_LOG2 + 1)'(1);
                default: r_level <= r_level;
            endcase

            if (w_pop) begin
                r_rptr   <= r_rptr + DEPTH_LOG2'(1);
                r_wave_l <= r_mem[r_rptr][2*BITWIDTH-1:BITWIDTH];
                r_wave_r <= r_mem[r_rptr][BITWIDTH-1:0];
            end else if (w_empty_tick) begin
`ifdef I2S_FIFO_HOLD_EN
                r_wave_l <= r_wave_l;
                r_wave_r <= r_wave_r;
`else
                r_wave_l <= '0;
                r_wave_r <= '0;
`endif
            end

            if (w_empty_tick && (r_underrun_cnt != 16'hFFFF)) begin
                r_underrun_cnt <= r_underrun_cnt + 16'd1;
            end
        end
    end

    assign s_if.s_ready   = w_ready;
    assign o_wave_out_l   = r_wave_l;
    assign o_wave_out_r   = r_wave_r;
    assign o_level        = r_level;
    assign o_underrun     = r_underrun;
    assign o_underrun_cnt = r_underrun_cnt;
endmodule

// File: tb/tb_i2s_sample_fifo.sv
// Self-checking bench for i2s_sample_fifo: vector table plus queue scoreboard of pushed pairs.
module tb_i2s_sample_fifo;
    localparam int BW    = 24;
    localparam int DL2   = 4;
    localparam int DEPTH = 1 << DL2;
`ifdef I2S_FIFO_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic           lrck;
    logic [BW-1:0]  wave_l;
    logic [BW-1:0]  wave_r;
    logic [DL2:0]   level;
    logic           underrun;
    logic [15:0]    ucnt;

    i2s_sample_fifo_if #(.BITWIDTH(BW)) sif ();

    i2s_sample_fifo #(.BITWIDTH(BW), .DEPTH_LOG2(DL2)) dut (
        .i_ctl_clk      (clk),
        .i_ctl_rst      (rst),
        .s_if           (sif),
        .i_lrck         (lrck),
        .o_wave_out_l   (wave_l),
        .o_wave_out_r   (wave_r),
        .o_level        (level),
        .o_underrun     (underrun),
        .o_underrun_cnt (ucnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;

    // Reference model state.
    logic [2*BW-1:0] sb [$];
    logic [BW-1:0]   m_l;
    logic [BW-1:0]   m_r;
    logic            m_under;
    logic [15:0]     m_cnt;
    logic            m_lrck_d;

    typedef struct {
        logic          v;
        logic [BW-1:0] l;
        logic [BW-1:0] r;
        logic          lr;
        logic [DL2:0]  e_level;
        logic [BW-1:0] e_l;
        logic [BW-1:0] e_r;
        logic          e_under;
        logic [15:0]   e_cnt;
        logic          e_ready;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("level", 64'(level), 64'(sb.size()));
        chk("wave_l", 64'(wave_l), 64'(m_l));
        chk("wave_r", 64'(wave_r), 64'(m_r));
        chk("underrun", 64'(underrun), 64'(m_under));
        chk("underrun_cnt", 64'(ucnt), 64'(m_cnt));
        chk("s_ready", 64'(sif.s_ready), 64'(sb.size() < DEPTH));
    endtask

    // One clock cycle: drive inputs, advance the model, compare after the edge.
    task automatic step(input logic v, input logic [BW-1:0] l, input logic [BW-1:0] r,
                        input logic lr, output bit acc);
        logic          tick;
        logic [2*BW-1:0] e;
        sif.s_valid = v;
        sif.s_l     = l;
        sif.s_r     = r;
        lrck        = lr;
        tick = m_lrck_d & ~lr;
        acc  = v && (sb.size() < DEPTH);
        @(posedge clk);
        #1;
        m_lrck_d = lr;
        m_under  = 1'b0;
        if (tick) begin
            if (sb.size() > 0) begin
                e   = sb.pop_front();
                m_l = e[2*BW-1:BW];
                m_r = e[BW-1:0];
            end else begin
                m_under = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                if (!HOLD) begin
                    m_l = '0;
                    m_r = '0;
                end
            end
        end
        if (acc) sb.push_back({l, r});
        model_check();
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        sif.s_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        m_l      = '0;
        m_r      = '0;
        m_under  = 1'b0;
        m_cnt    = '0;
        m_lrck_d = 1'b0;
        model_check();
    endtask

    task automatic drain();
        bit a;
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(1'b0, '0, '0, 1'b1, a);
            step(1'b0, '0, '0, 1'b0, a);
        end
    endtask

    initial begin
        bit acc;
        int idx;
        int cyc;
        logic [BW-1:0] hl;

        rst         = 1'b1;
        lrck        = 1'b1;
        sif.s_valid = 1'b0;
        sif.s_l     = '0;
        sif.s_r     = '0;
        @(posedge clk);
        do_reset();

        hl = HOLD ? 24'h00ABCD : 24'h0;
        //          v     l          r          lr    lvl  e_l        e_r        und  cnt ready
        vecs[0]  = '{1'b0, 24'h0,     24'h0,     1'b1, 0, 24'h0,     24'h0,     1'b0, 0, 1'b1};
        vecs[1]  = '{1'b1, 24'h000111, 24'h000222, 1'b1, 1, 24'h0,   24'h0,     1'b0, 0, 1'b1};
        vecs[2]  = '{1'b0, 24'h0,     24'h0,     1'b0, 0, 24'h000111, 24'h000222, 1'b0, 0, 1'b1};
        vecs[3]  = '{1'b0, 24'h0,     24'h0,     1'b0, 0, 24'h000111, 24'h000222, 1'b0, 0, 1'b1};
        vecs[4]  = '{1'b1, 24'h00ABCD, 24'h00ABCD, 1'b1, 1, 24'h000111, 24'h000222, 1'b0, 0, 1'b1};
        vecs[5]  = '{1'b0, 24'h0,     24'h0,     1'b0, 0, 24'h00ABCD, 24'h00ABCD, 1'b0, 0, 1'b1};
        vecs[6]  = '{1'b0, 24'h0,     24'h0,     1'b1, 0, 24'h00ABCD, 24'h00ABCD, 1'b0, 0, 1'b1};
        vecs[7]  = '{1'b0, 24'h0,     24'h0,     1'b0, 0, hl,        hl,        1'b1, 1, 1'b1};
        vecs[8]  = '{1'b0, 24'h0,     24'h0,     1'b0, 0, hl,        hl,        1'b0, 1, 1'b1};
        vecs[9]  = '{1'b1, 24'h000005, 24'h000006, 1'b1, 1, hl,      hl,        1'b0, 1, 1'b1};
        vecs[10] = '{1'b1, 24'h000007, 24'h000008, 1'b0, 1, 24'h000005, 24'h000006, 1'b0, 1, 1'b1};
        vecs[11] = '{1'b0, 24'h0,     24'h0,     1'b1, 1, 24'h000005, 24'h000006, 1'b0, 1, 1'b1};

        for (int i = 0; i < 12; i++) begin
            step(vecs[i].v, vecs[i].l, vecs[i].r, vecs[i].lr, acc);
            chk($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].e_level));
            chk($sformatf("vec%0d_wave_l", i), 64'(wave_l), 64'(vecs[i].e_l));
            chk($sformatf("vec%0d_wave_r", i), 64'(wave_r), 64'(vecs[i].e_r));
            chk($sformatf("vec%0d_underrun", i), 64'(underrun), 64'(vecs[i].e_under));
            chk($sformatf("vec%0d_cnt", i), 64'(ucnt), 64'(vecs[i].e_cnt));
            chk($sformatf("vec%0d_ready", i), 64'(sif.s_ready), 64'(vecs[i].e_ready));
        end

        // Fill to full with no ticks; the 17th offer must be refused.
        drain();
        for (int i = 0; i < DEPTH + 1; i++) begin
            step(1'b1, BW'(24'h100 + i), BW'(24'h200 + i), 1'b1, acc);
            if (i == DEPTH) chk("full_17th_refused", 64'(acc), 64'(0));
        end
        chk("full_level", 64'(level), 64'(DEPTH));
        chk("full_ready", 64'(sif.s_ready), 64'(0));
        step(1'b1, 24'hFFFFFF, 24'hFFFFFF, 1'b0, acc);
        chk("full_tick_level", 64'(level), 64'(DEPTH - 1));
        chk("full_tick_ready", 64'(sif.s_ready), 64'(1));
        chk("full_tick_wave_l", 64'(wave_l), 64'(24'h100));

        // Ordering across pointer wrap: 40 pairs, a tick every 32 cycles.
        drain();
        idx = 0;
        cyc = 0;
        while ((idx < 40 || sb.size() > 0) && cyc < 4000) begin
            step(idx < 40, BW'(idx), BW'(idx + 1000), ((cyc % 32) < 16), acc);
            if (acc) idx++;
            cyc++;
        end
        chk("wrap_timeout", 64'(cyc < 4000), 64'(1));
        chk("wrap_last_l", 64'(wave_l), 64'(39));
        chk("wrap_no_underrun", 64'(ucnt), 64'(m_cnt));

        // Push and tick together with level 3.
        drain();
        step(1'b0, '0, '0, 1'b1, acc);
        for (int i = 0; i < 3; i++) step(1'b1, BW'(24'h30 + i), BW'(24'h40 + i), 1'b1, acc);
        step(1'b1, 24'h33, 24'h43, 1'b0, acc);
        chk("sim_lvl3_level", 64'(level), 64'(3));
        chk("sim_lvl3_wave_l", 64'(wave_l), 64'(24'h30));
        drain();

        // Push and tick together while empty: underrun, pair still stored.
        step(1'b0, '0, '0, 1'b1, acc);
        cyc = int'(ucnt);
        step(1'b1, 24'h55, 24'h66, 1'b0, acc);
        chk("sim_empty_underrun", 64'(underrun), 64'(1));
        chk("sim_empty_level", 64'(level), 64'(1));
        chk("sim_empty_cnt", 64'(ucnt), 64'(cyc + 1));
        step(1'b0, '0, '0, 1'b1, acc);
        chk("sim_empty_pulse_end", 64'(underrun), 64'(0));

        // Reset mid-stream with level 5.
        for (int i = 0; i < 4; i++) step(1'b1, BW'(24'h70 + i), BW'(24'h80 + i), 1'b1, acc);
        chk("mid_level5", 64'(level), 64'(5));
        do_reset();
        chk("mid_rst_level", 64'(level), 64'(0));
        chk("mid_rst_wave_l", 64'(wave_l), 64'(0));
        step(1'b0, '0, '0, 1'b1, acc);
        step(1'b0, '0, '0, 1'b0, acc);
        chk("mid_rst_underrun", 64'(underrun), 64'(1));
        chk("mid_rst_cnt", 64'(ucnt), 64'(1));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/i2s_sample_fifo.md
# i2s_sample_fifo

Stereo sample buffer in the `ctl_clk` domain, directly upstream of the I2S transmitter. It accepts left/right sample pairs from the synthesizer voice mixer over a valid/ready handshake and stores them in a circular FIFO. It presents exactly one new pair per LR frame on `wave_out_l`/`wave_out_r`, which drive the transmitter's `wave_in_l`/`wave_in_r`. Underruns are reported and counted.

## Interface
- `BITWIDTH`, 24: sample width per channel.
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 stereo pairs.

- `ctl_clk` in 1: sole clock (100 MHz control clock).
- `ctl_rst` in 1: reset, synchronous, active-high.
- `s_l` in BITWIDTH: left sample to push.
- `s_r` in BITWIDTH: right sample to push.
- `s_valid` in 1: push request.
- `s_ready` out 1: FIFO can accept; push occurs when `s_valid && s_ready`.
- `lrck` in 1: transmitter LR clock; it is divided from `ctl_clk`, so no synchronizer. Low means left frame.
- `wave_out_l` out BITWIDTH: held left sample to the transmitter.
- `wave_out_r` out BITWIDTH: held right sample to the transmitter.
- `level` out DEPTH_LOG2+1: current occupancy, 0..2^DEPTH_LOG2.
- `underrun` out 1: one-cycle pulse on a frame start with an empty FIFO.
- `underrun_cnt` out 16: saturating count of underruns.

## Operation
- Storage: 2^DEPTH_LOG2 entries of 2*BITWIDTH bits. Write pointer and read pointer are DEPTH_LOG2 bits wide and wrap modulo depth. `level` is a separate registered counter.
- `s_ready = (level != 2^DEPTH_LOG2)`. It is decoded from the registered level, with no combinational path from `lrck`.
- Frame tick:
  - `lrck_d` registers `lrck` every cycle.
  - `tick = lrck_d & ~lrck`, i.e. a falling LR edge marks the start of the left half-frame.
- On a tick with `level > 0`:
  - Read the entry at the read pointer into `wave_out_l`/`wave_out_r`.
  - Increment the read pointer.
  - Decrement `level`.
- On a tick with `level == 0`:
  - Assert `underrun` for one cycle.
  - `underrun_cnt` increments, saturating at 0xFFFF.
  - Outputs follow the Configuration rule.
- Push without a tick: write at the write pointer, increment the write pointer, increment `level`.
- Simultaneous push and pop: both pointers advance and `level` is unchanged.
- Simultaneous push and tick while empty: the tick is an underrun. There is no bypass; the pushed pair is stored and `level` becomes 1.
- Full: `s_ready` = 0 and pushes are ignored. A tick in the same cycle pops, and `s_ready` returns to 1 on the next cycle.
- Outputs hold their value between ticks.

## Timing
- Reset values (all synchronous with `ctl_rst`=1):
  - `wave_out_l`/`wave_out_r` = 0
  - `level` = 0
  - both pointers = 0
  - `underrun` = 0
  - `underrun_cnt` = 0
  - `lrck_d` = 0, so no spurious tick if `lrck` is low at release
  - `s_ready` = 1 on the first cycle after reset
- Reset asserted mid-operation discards all stored pairs; the next tick after release is an underrun unless a push has occurred.
- Latency:
  - Tick is combinational in the first cycle `lrck` is sampled low.
  - `wave_out_*`, `level` and `underrun` update at the following `ctl_clk` edge, one cycle after the edge.
  - Outputs are therefore stable well before the transmitter's next BCLK falling edge loads them.
- Push to `level` change: 1 cycle. Push to earliest visibility on `wave_out_*`: the next tick after the push cycle.
- Throughput: one push per cycle; one pop per LR frame.

## Configuration
- `I2S_FIFO_HOLD_EN` defined: on underrun, `wave_out_l`/`wave_out_r` keep their previous value (last sample repeated).
- Undefined: on underrun, both outputs are forced to 0 (mute).
- `underrun` and `underrun_cnt` behave identically in both builds.

## Test plan
- **Reset, then basic pop:** push (L=0x000111, R=0x000222) while `lrck`=1, then drive `lrck` 1→0.
  - Before the push: `level`=0, outputs 0, `s_ready`=1.
  - After the push: `level`=1.
  - One cycle after the edge: outputs 0x000111/0x000222, `level`=0.
- **Fill to full (DEPTH_LOG2=4):** hold `s_valid` high with no ticks.
  - After 16 accepted pushes: `level`=16, `s_ready`=0.
  - A 17th push is not stored.
  - One tick, then `s_ready`=1 and `level`=15.
- **Ordering and wrap:** push 40 incrementing pairs while ticking every 32 cycles.
  - Popped sequence is 0..39 in order with no gaps across pointer wrap.
  - `underrun_cnt`=0 until the FIFO drains.
- **Underrun:** tick while empty after last output 0x00ABCD.
  - `underrun` pulses for 1 cycle and `underrun_cnt`=1.
  - Outputs stay 0x00ABCD with `I2S_FIFO_HOLD_EN`, else become 0.
- **Simultaneous events:**
  - Push and tick in the same cycle with `level`=3: `level` stays 3 and pop order is preserved.
  - Same with `level`=0: underrun, then `level`=1.
- **Reset mid-stream:** assert `ctl_rst` for 1 cycle with `level`=5.
  - `level`=0 and outputs 0.
  - Next tick is an underrun.
